tdm_demux_1x8: RTL and testbench

- Time-division 1-to-8 demultiplexer, the receive-side counterpart of the team's 8:1 selection path.
- Takes a serialised stream of samples, one per valid beat, framed by a sync marker.
- Steers each sample to channel slot 0..7 in order, double-buffers the frame, and presents all eight channels in parallel with a one-cycle valid strobe.
- Sits after a serial link or muxed bus to recover per-channel data.

---
 rtl/tdm_demux_1x8_if.sv | 23 ++
 rtl/tdm_demux_1x8.sv | 81 ++++++++
 tb/tb_tdm_demux_1x8.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/tdm_demux_1x8_if.sv
// Serial sample input and parallel frame output bundle of the 1:8 TDM demultiplexer.
interface tdm_demux_1x8_if #(
   parameter int W = 4
);
   logic [W-1:0]   din;
   logic           din_vld;
   logic           fsync;
   logic [8*W-1:0] y;
   logic           y_vld;
   logic [2:0]     slot;
   logic           locked;
   logic           err;

   modport master (
      output din, din_vld, fsync,
      input  y, y_vld, slot, locked, err
   );

   modport slave (
      input  din, din_vld, fsync,
      output y, y_vld, slot, locked, err
   );
endinterface

// File: rtl/tdm_demux_1x8.sv
// 1:8 TDM demux: fsync-framed serial samples are staged and released as a parallel frame
// one cycle after the slot-7 beat; no backpressure, one sample accepted per valid beat.
module tdm_demux_1x8 #(
   parameter int W = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   tdm_demux_1x8_if.slave bus
);

   typedef enum logic {HUNT = 1'b0, FILL = 1'b1} state_t;

   state_t              state_q, state_d;
   logic [2:0]          cnt_q, cnt_d;
   logic [7:0][W-1:0]   stg_q, stg_d;
   logic [8*W-1:0]      y_q, y_d;
   logic                y_vld_q, y_vld_d;
   logic                err_q, err_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      stg_d   = stg_q;
      y_d     = y_q;
      y_vld_d = 1'b0;
      err_d   = 1'b0;

      if (bus.din_vld) begin
         case (state_q)
            HUNT: begin
               if (bus.fsync) begin
                  stg_d[0] = bus.din;
                  cnt_d    = 3'd1;
                  state_d  = FILL;
               end
            end
            FILL: begin
               if (bus.fsync) begin
                  // A sync anywhere but a frame boundary drops the partial frame.
                  err_d    = (cnt_q != 3'd0);
                  stg_d[0] = bus.din;
                  cnt_d    = 3'd1;
               end else begin
                  stg_d[cnt_q] = bus.din;
                  cnt_d        = cnt_q + 3'd1;
                  if (cnt_q == 3'd7) begin
                     y_d     = {bus.din, stg_q[6:0]};
                     y_vld_d = 1'b1;
                  end
               end
            end
            default: state_d = HUNT;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= HUNT;
         cnt_q   <= 3'd0;
         stg_q   <= '0;
         y_q     <= '0;
         y_vld_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         stg_q   <= stg_d;
         y_q     <= y_d;
         y_vld_q <= y_vld_d;
         err_q   <= err_d;
      end
   end

   assign bus.y      = y_q;
   assign bus.y_vld  = y_vld_q;
   assign bus.slot   = cnt_q;
   assign bus.locked = (state_q == FILL);
   assign bus.err    = err_q;

endmodule

// File: tb/tb_tdm_demux_1x8.sv
// Directed bench for tdm_demux_1x8: expected frames and error pulses are queued with
// the cycle they must appear on and checked by a negedge monitor.
module tb_tdm_demux_1x8;

   typedef struct {
      int          cyc;
      logic [31:0] y;
   } exp_t;

   logic clk;
   logic rst_n;
   int   cyc;
   int   checks;
   int   failures;
   exp_t exp_q[$];
   int   err_q[$];

   tdm_demux_1x8_if #(.W(4)) bus ();

   tdm_demux_1x8 #(.W(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      int   ec;
      if (bus.y_vld === 1'b1 || bus.err === 1'b1)
         chk("vld_err_exclusive", {31'b0, bus.y_vld & bus.err}, 32'd0);
      if (bus.y_vld === 1'b1) begin
         chk("y_vld_expected", {31'b0, exp_q.size() != 0}, 32'd1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("y_vld_cycle", cyc, e.cyc);
            chk("y_frame", bus.y, e.y);
         end
      end
      if (bus.err === 1'b1) begin
         chk("err_expected", {31'b0, err_q.size() != 0}, 32'd1);
         if (err_q.size() != 0) begin
            ec = err_q.pop_front();
            chk("err_cycle", cyc, ec);
         end
      end
   end

   task automatic beat(input logic [3:0] d, input logic fs);
      @(negedge clk);
      bus.din     = d;
      bus.fsync   = fs;
      bus.din_vld = 1'b1;
   endtask

   task automatic idle();
      @(negedge clk);
      bus.din_vld = 1'b0;
      bus.fsync   = 1'b0;
   endtask

   task automatic send_frame(input logic [31:0] f, input int gap_a, input int gap_b);
      for (int k = 0; k < 8; k++) begin
         beat(f[k*4 +: 4], k == 0);
         if (k == 7) exp_q.push_back('{cyc + 1, f});
         if (k == gap_a || k == gap_b) begin
            idle();
            @(negedge clk);
            chk("slot_hold_gap", {29'b0, bus.slot}, k + 1);
         end
      end
   endtask

   initial begin
      checks      = 0;
      failures    = 0;
      rst_n       = 1'b0;
      bus.din     = 4'h5;
      bus.fsync   = 1'b1;
      bus.din_vld = 1'b0;

      // Reset held across two edges while din_vld toggles.
      @(negedge clk);
      bus.din_vld = 1'b1;
      @(negedge clk);
      bus.din_vld = 1'b0;
      chk("rst_y", bus.y, 32'd0);
      chk("rst_y_vld", {31'b0, bus.y_vld}, 32'd0);
      chk("rst_slot", {29'b0, bus.slot}, 32'd0);
      chk("rst_locked", {31'b0, bus.locked}, 32'd0);
      chk("rst_err", {31'b0, bus.err}, 32'd0);
      rst_n     = 1'b1;
      bus.fsync = 1'b0;

      // HUNT discards unsynced samples.
      for (int i = 0; i < 3; i++) beat(4'hF, 1'b0);
      idle();
      @(negedge clk);
      chk("hunt_locked", {31'b0, bus.locked}, 32'd0);
      chk("hunt_slot", {29'b0, bus.slot}, 32'd0);

      beat(4'h1, 1'b1);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1 rst_n = 1'b1;
      @(negedge clk);
      bus.din_vld = 1'b0;
      chk("lock_after_fsync", {31'b0, bus.locked}, 32'd1);
      chk("slot_after_fsync", {29'b0, bus.slot}, 32'd1);
      for (int k = 2; k <= 8; k++) begin
         beat(k[3:0], 1'b0);
         if (k == 8) exp_q.push_back('{cyc + 1, 32'h87654321});
      end
      idle();
      repeat (2) @(negedge clk);

      // Back-to-back frames with no bubble.
      send_frame(32'h76543210, -1, -1);
      send_frame(32'hFEDCBA98, -1, -1);
      idle();
      repeat (2) @(negedge clk);
      chk("y_hold", bus.y, 32'hFEDCBA98);

      // Gaps after slots 2 and 5.
      send_frame(32'h76543210, 2, 5);
      idle();
      repeat (2) @(negedge clk);

      // Short frame: resync after four samples.
      beat(4'h1, 1'b1);
      beat(4'h2, 1'b0);
      beat(4'h3, 1'b0);
      beat(4'h4, 1'b0);
      beat(4'hA, 1'b1);
      err_q.push_back(cyc + 1);
      beat(4'hB, 1'b0);
      beat(4'hC, 1'b0);
      beat(4'hD, 1'b0);
      beat(4'hE, 1'b0);
      beat(4'hF, 1'b0);
      beat(4'h0, 1'b0);
      beat(4'h1, 1'b0);
      exp_q.push_back('{cyc + 1, 32'h10FEDCBA});
      idle();
      repeat (2) @(negedge clk);

      // Reset at slot 6 after six samples; relock needs fsync.
      for (int k = 0; k < 6; k++) beat(k[3:0], k == 0);
      @(negedge clk);
      bus.din_vld = 1'b0;
      rst_n       = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("midrst_locked", {31'b0, bus.locked}, 32'd0);
      chk("midrst_slot", {29'b0, bus.slot}, 32'd0);
      chk("midrst_y", bus.y, 32'd0);
      beat(4'h9, 1'b0);
      idle();
      @(negedge clk);
      chk("midrst_no_lock", {31'b0, bus.locked}, 32'd0);
      send_frame(32'h76543210, -1, -1);
      idle();
      repeat (3) @(negedge clk);

      chk("final_y", bus.y, 32'h76543210);
      chk("final_locked", {31'b0, bus.locked}, 32'd1);
      chk("frames_drained", exp_q.size(), 32'd0);
      chk("errs_drained", err_q.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
